// File: rtl/mod_n_pkg.sv
// Shared types and helpers for the serial mod-N checker.
package mod_n_pkg;

  typedef enum logic {
    MODE_MSB = 1'b0,
    MODE_LSB = 1'b1
  } mode_e;

  // Wide enough for 2*(DIVISOR-1)+1 with DIVISOR up to 255.
  localparam int unsigned RED_W = 9;

  function automatic logic [RED_W-1:0] mod_reduce(input logic [RED_W-1:0] t,
                                                  input logic [RED_W-1:0] d);
    return (t >= d) ? (t - d) : t;
  endfunction

endpackage

// File: rtl/mod_n_serial_checker_tick_gen.sv
// Step-rate divider: one-cycle tick every TICK_DIV clocks plus a square-wave indicator.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic slow_clock
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;
  logic          slow_q, slow_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    tick_d    = (div_cnt_q == LAST);
    slow_d    = (div_cnt_q >= HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
    end
  end

  assign tick       = tick_q;
  assign slow_clock = slow_q;

endmodule

// File: rtl/mod_n_serial_checker.sv
// Serial divisibility checker: tracks the running value mod DIVISOR, MSB- or LSB-first.
module mod_n_serial_checker
  import mod_n_pkg::*;
#(
  parameter int unsigned DIVISOR  = 3,
  parameter int unsigned TICK_DIV = 4000000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RW       = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             lsb_first,
  input  logic             clear,
  output logic             tick,
  output logic             slow_clock,
  output logic             cout,
  output logic [RW-1:0]    remainder,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [RED_W-1:0] D9 = RED_W'(DIVISOR);

  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  mode_e            mode_q, mode_d;

  logic [RED_W-1:0] t_msb, t_lsb, w_dbl, rem_next;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .slow_clock(slow_clock)
  );

  always_comb begin
    rem_d    = rem_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    cout_d   = cout_q;
    mode_d   = mode_q;
    rem_next = '0;
    t_msb    = RED_W'({rem_q, sel});
    t_lsb    = RED_W'(rem_q) + (sel ? RED_W'(w_q) : '0);
    w_dbl    = RED_W'({w_q, 1'b0});
    // clear wins over a coincident tick, so that bit is dropped
    if (clear) begin
      rem_d  = '0;
      w_d    = RW'(1);
      cnt_d  = '0;
      cout_d = 1'b1;
      mode_d = mode_e'(lsb_first);
    end else if (tick) begin
      if (mode_q == MODE_LSB) begin
        rem_next = mod_reduce(t_lsb, D9);
        w_d      = RW'(mod_reduce(w_dbl, D9));
      end else begin
        rem_next = mod_reduce(t_msb, D9);
      end
      rem_d  = RW'(rem_next);
      cout_d = (rem_next == '0);
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      w_q    <= RW'(1);
      cnt_q  <= '0;
      cout_q <= 1'b1;
      mode_q <= mode_e'(lsb_first);
    end else begin
      rem_q  <= rem_d;
      w_q    <= w_d;
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
      mode_q <= mode_d;
    end
  end

  assign remainder = rem_q;
  assign bit_count = cnt_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_mod_n_serial_checker.sv
// Scoreboard bench for mod_n_serial_checker across four parameter sets.
module tb_mod_n_serial_checker;

  typedef struct {
    int          which;
    int unsigned rem;
    int unsigned cnt;
  } exp_t;

  logic clk;
  logic rst_v [4];
  logic sel_v [4];
  logic lsb_v [4];
  logic clr_v [4];
  logic tick_v[4];
  logic slow_v[4];
  logic cout_v[4];
  logic [31:0] rem_v[4];
  logic [31:0] cnt_v[4];

  logic [1:0] rem_a, rem_d;
  logic [2:0] rem_b, rem_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [3:0] cnt_d;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned dv  [4] = '{3, 5, 7, 3};
  int unsigned cmax[4] = '{255, 255, 255, 15};
  int unsigned m_val[4];
  int unsigned m_pow[4];
  int unsigned m_cnt[4];
  bit          m_lsb[4];
  exp_t        sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_n_serial_checker #(.DIVISOR(3), .TICK_DIV(4), .CNT_W(8)) u_a (
    .clk(clk), .reset(rst_v[0]), .sel(sel_v[0]), .lsb_first(lsb_v[0]), .clear(clr_v[0]),
    .tick(tick_v[0]), .slow_clock(slow_v[0]), .cout(cout_v[0]), .remainder(rem_a), .bit_count(cnt_a));

  mod_n_serial_checker #(.DIVISOR(5), .TICK_DIV(4), .CNT_W(8)) u_b (
    .clk(clk), .reset(rst_v[1]), .sel(sel_v[1]), .lsb_first(lsb_v[1]), .clear(clr_v[1]),
    .tick(tick_v[1]), .slow_clock(slow_v[1]), .cout(cout_v[1]), .remainder(rem_b), .bit_count(cnt_b));

  mod_n_serial_checker #(.DIVISOR(7), .TICK_DIV(4), .CNT_W(8)) u_c (
    .clk(clk), .reset(rst_v[2]), .sel(sel_v[2]), .lsb_first(lsb_v[2]), .clear(clr_v[2]),
    .tick(tick_v[2]), .slow_clock(slow_v[2]), .cout(cout_v[2]), .remainder(rem_c), .bit_count(cnt_c));

  mod_n_serial_checker #(.DIVISOR(3), .TICK_DIV(1), .CNT_W(4)) u_d (
    .clk(clk), .reset(rst_v[3]), .sel(sel_v[3]), .lsb_first(lsb_v[3]), .clear(clr_v[3]),
    .tick(tick_v[3]), .slow_clock(slow_v[3]), .cout(cout_v[3]), .remainder(rem_d), .bit_count(cnt_d));

  assign rem_v[0] = 32'(rem_a);
  assign rem_v[1] = 32'(rem_b);
  assign rem_v[2] = 32'(rem_c);
  assign rem_v[3] = 32'(rem_d);
  assign cnt_v[0] = 32'(cnt_a);
  assign cnt_v[1] = 32'(cnt_b);
  assign cnt_v[2] = 32'(cnt_c);
  assign cnt_v[3] = 32'(cnt_d);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_restart(input int w, input bit lsb);
    m_val[w] = 0;
    m_pow[w] = 1 % dv[w];
    m_cnt[w] = 0;
    m_lsb[w] = lsb;
  endtask

  task automatic wait_tick(input int w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tick_v[w] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear(input int w, input bit lsb);
    @(negedge clk);
    clr_v[w] = 1'b1;
    lsb_v[w] = lsb;
    @(posedge clk);
    #1;
    clr_v[w] = 1'b0;
    model_restart(w, lsb);
  endtask

  task automatic do_step(input int w, input bit b);
    bit   ok;
    exp_t e;
    wait_tick(w, ok);
    if (!ok) return;
    sel_v[w] = b;
    if (m_lsb[w]) begin
      m_val[w] = (m_val[w] + (b ? m_pow[w] : 0)) % dv[w];
      m_pow[w] = (m_pow[w] * 2) % dv[w];
    end else begin
      m_val[w] = (m_val[w] * 2 + (b ? 1 : 0)) % dv[w];
    end
    if (m_cnt[w] < cmax[w]) m_cnt[w]++;
    sb_q.push_back('{which: w, rem: m_val[w], cnt: m_cnt[w]});
    @(posedge clk);
    #1;
    sel_v[w] = 1'b0;
    e = sb_q.pop_front();
    check_eq($sformatf("rem[%0d]", e.which), rem_v[e.which], e.rem);
    check_eq($sformatf("cout[%0d]", e.which), 32'(cout_v[e.which]), 32'(e.rem == 0));
    check_eq($sformatf("cnt[%0d]", e.which), cnt_v[e.which], e.cnt);
  endtask

  task automatic check_restart(input int w, input string tag);
    check_eq({tag, "_rem"}, rem_v[w], 32'd0);
    check_eq({tag, "_cout"}, 32'(cout_v[w]), 32'd1);
    check_eq({tag, "_cnt"}, cnt_v[w], 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1;
      sel_v[i] = 1'b0;
      clr_v[i] = 1'b0;
      lsb_v[i] = (i == 1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_restart(i, $sformatf("reset%0d", i));
      check_eq($sformatf("reset%0d_tick", i), 32'(tick_v[i]), 32'd0);
      check_eq($sformatf("reset%0d_slow", i), 32'(slow_v[i]), 32'd0);
      rst_v[i] = 1'b0;
    end

    // Divider on instance A: tick at cycles 4,8,12; slow_clock low 2, high 2.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("div_tick_c%0d", k), 32'(tick_v[0]), 32'((k % 4) == 0));
      check_eq($sformatf("div_slow_c%0d", k), 32'(slow_v[0]), 32'(((k - 1) % 4) >= 2));
    end

    // MSB-first, DIVISOR=3: 1,1,0 -> rem 1,0,0.
    do_clear(0, 1'b0);
    do_step(0, 1'b1);
    do_step(0, 1'b1);
    do_step(0, 1'b0);
    check_eq("msb6_final_rem", rem_v[0], 32'd0);

    // clear coinciding with tick drops the bit.
    do_clear(0, 1'b0);
    do_step(0, 1'b1);
    wait_tick(0, ok);
    if (ok) begin
      clr_v[0] = 1'b1;
      sel_v[0] = 1'b1;
      @(posedge clk);
      #1;
      clr_v[0] = 1'b0;
      sel_v[0] = 1'b0;
      model_restart(0, 1'b0);
      check_restart(0, "clr_tick");
    end
    // lsb_first toggled mid-stream is ignored until the next clear.
    do_step(0, 1'b1);
    do_step(0, 1'b1);
    lsb_v[0] = 1'b1;
    do_step(0, 1'b0);
    do_step(0, 1'b1);
    do_clear(0, 1'b1);
    do_step(0, 1'b1);
    do_step(0, 1'b0);
    do_step(0, 1'b1);

    // LSB-first, DIVISOR=5: 1,0,1 -> weight 1,2,4; rem 1,1,0.
    do_clear(1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("lsb_weight%0d", i), 32'(u_b.w_q), m_pow[1]);
      do_step(1, (i != 1));
    end
    check_eq("lsb5_final_cout", 32'(cout_v[1]), 32'd1);

    // Reset mid-stream, DIVISOR=7.
    do_clear(2, 1'b0);
    do_step(2, 1'b1);
    do_step(2, 1'b0);
    @(negedge clk);
    rst_v[2] = 1'b1;
    @(posedge clk);
    #1;
    check_restart(2, "midrst");
    check_eq("midrst_tick", 32'(tick_v[2]), 32'd0);
    check_eq("midrst_slow", 32'(slow_v[2]), 32'd0);
    @(negedge clk);
    rst_v[2] = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (tick_v[2] === 1'b1) begin
        n = i;
        break;
      end
    end
    check_eq("midrst_first_tick_cycle", 32'(n), 32'd4);

    // Saturation: CNT_W=4, TICK_DIV=1, twenty 1 bits.
    do_clear(3, 1'b0);
    for (int i = 0; i < 20; i++) do_step(3, 1'b1);
    check_eq("sat_cnt", cnt_v[3], 32'd15);
    check_eq("sat_rem", rem_v[3], 32'd0);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
